// File: rtl/gs_pipeline_ctrl.sv
// Frame sequencer for the grayscale pipeline: RWM_1 load, Grayscaler pass, RWM_2 flush, with pixel count check and watchdog.
// Latency: start -> rwm1_load 1 cycle, rwm2_done -> done 1 cycle; no backpressure, stalls are bounded by the watchdog.
module gs_pipeline_ctrl #(
    parameter int N     = 64,
    parameter int M     = 64,
    parameter int CNT_W = 13,
    parameter int TMO   = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             clr_err,
    input  logic             rwm1_done,
    input  logic             gs_valid,
    input  logic             gs_done,
    input  logic             rwm2_done,
    output logic             rwm1_load,
    output logic             rwm1_read,
    output logic             gs_enable,
    output logic             rwm2_write,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pix_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [CNT_W:0]   PIX_TARGET = (CNT_W+1)'(N * M);
    localparam logic [CNT_W-1:0] PIX_MAX    = '1;
    localparam logic [15:0]      WDOG_LAST  = 16'(TMO - 1);

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [15:0]    wdog;
    logic           wdog_active;
    logic           timeout;
    logic           abort_hit;
    logic [CNT_W:0] pix_final;
    logic           pix_ok;

    assign wdog_active = (state == S_LOAD) || (state == S_RUN) || (state == S_FLUSH);
    // A strobe on the last allowed cycle counts as progress, so it never times out.
    assign timeout     = wdog_active && !gs_valid && (wdog >= WDOG_LAST);
    assign abort_hit   = abort && (state != S_IDLE) && (state != S_ERR);
    assign pix_final   = {1'b0, pix_cnt} + (CNT_W+1)'(gs_valid);
    assign pix_ok      = (pix_final == PIX_TARGET);

    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end else if (timeout) begin
            state_nxt = S_ERR;
        end else begin
            case (state)
                S_IDLE:  if (start)     state_nxt = S_LOAD;
                S_LOAD:  if (rwm1_done) state_nxt = S_RUN;
                S_RUN:   if (gs_done)   state_nxt = pix_ok ? S_FLUSH : S_ERR;
                S_FLUSH: if (rwm2_done) state_nxt = S_DONE;
                S_DONE:                 state_nxt = S_IDLE;
                S_ERR:   if (clr_err)   state_nxt = S_IDLE;
                default:                state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wdog     <= '0;
            pix_cnt  <= '0;
            err_code <= 2'b00;
        end else begin
            state <= state_nxt;

            if (!wdog_active || (state_nxt != state) || gs_valid) begin
                wdog <= '0;
            end else if (wdog != 16'hFFFF) begin
                wdog <= wdog + 16'd1;
            end

            if ((state == S_IDLE) && start) begin
                pix_cnt <= '0;
            end else if ((state == S_RUN) && gs_valid && (pix_cnt != PIX_MAX)) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end

            if ((state == S_IDLE) && start) begin
                err_code <= 2'b00;
            end else if (!abort_hit && timeout) begin
                err_code <= 2'b01;
            end else if (!abort_hit && (state == S_RUN) && gs_done && !pix_ok) begin
                err_code <= 2'b10;
            end
        end
    end

    // Outputs are flops loaded from the next state so each one switches on the edge entering its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwm1_load  <= 1'b0;
            rwm1_read  <= 1'b0;
            gs_enable  <= 1'b0;
            rwm2_write <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            rwm1_load  <= (state_nxt == S_LOAD);
            rwm1_read  <= (state_nxt == S_RUN);
            gs_enable  <= (state_nxt == S_RUN);
            rwm2_write <= (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
            busy       <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
            done       <= (state_nxt == S_DONE);
            err        <= (state_nxt == S_ERR);
        end
    end

endmodule
